// File: rtl/hc595_frame_scheduler_pkg.sv
// Shared types and defaults for the SN74HC595 frame scheduler.
package hc595_frame_scheduler_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StLatch,
    StGap
  } hc595_state_e;

  localparam int unsigned HC595_DATA_W      = 8;
  localparam int unsigned HC595_CLK_DIV     = 4;
  localparam int unsigned HC595_REFRESH_CYC = 12000;

  // Counter width that stays at least one bit for degenerate ranges.
  function automatic int unsigned min_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hc595_frame_scheduler_if.sv
// Requester handshakes and HC595 pin bundle for the frame scheduler.
interface hc595_frame_scheduler_if
  import hc595_frame_scheduler_pkg::*;
#(
  parameter int unsigned DATA_W = HC595_DATA_W
);
  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              busy;
  logic              frame_done;
  logic              last_grant;
  logic              SN74HC595_data;
  logic              SN74HC595_data_clk;
  logic              SN74HC595_refresh_clk;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready, busy, frame_done, last_grant,
    input  SN74HC595_data, SN74HC595_data_clk, SN74HC595_refresh_clk
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready, busy, frame_done, last_grant,
    output SN74HC595_data, SN74HC595_data_clk, SN74HC595_refresh_clk
  );
endinterface

// File: rtl/hc595_frame_scheduler_rr_arb2.sv
// Two-way round-robin grant: on a tie the source not granted last wins.
module rr_arb2 (
  input  logic en_i,
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_grant_i,
  output logic grant0_o,
  output logic grant1_o
);
  assign grant0_o = en_i & valid0_i & (~valid1_i | last_grant_i);
  assign grant1_o = en_i & valid1_i & (~valid0_i | ~last_grant_i);
endmodule

// File: rtl/hc595_frame_scheduler.sv
// Shares one SN74HC595 chain between two frame requesters: arbitrate, shift MSB-first with a
// divided clock, pulse the latch, and re-send the last frame after a programmable idle time.
module hc595_frame_scheduler
  import hc595_frame_scheduler_pkg::*;
#(
  parameter int unsigned DATA_W      = HC595_DATA_W,
  parameter int unsigned CLK_DIV     = HC595_CLK_DIV,
  parameter int unsigned REFRESH_CYC = HC595_REFRESH_CYC
) (
  input logic                    clk,
  input logic                    rst_n,
  hc595_frame_scheduler_if.slave bus
);
  localparam int unsigned DivW  = min_width(CLK_DIV);
  localparam int unsigned BitW  = min_width(DATA_W);
  localparam int unsigned IdleW = min_width(REFRESH_CYC + 1);

  localparam logic [DivW-1:0]  DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0]  DivPre   = (CLK_DIV > 1) ? DivW'(CLK_DIV - 2) : '0;
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_W - 1);
  localparam logic [IdleW-1:0] IdleTrig = IdleW'(REFRESH_CYC - 1);

  hc595_state_e      state_q;
  logic [DivW-1:0]   div_q;
  logic [BitW-1:0]   bit_q;
  logic [IdleW-1:0]  idle_q;
  logic [DATA_W-1:0] shreg_q, shadow_q;
  logic              last_grant_q, data_q, data_clk_q, refresh_clk_q, frame_done_q;

  logic              grant0, grant1, accept, refresh_start, div_wrap;
  logic [DATA_W-1:0] accept_data, shreg_nxt;

  rr_arb2 u_arb (
    .en_i        (rst_n && (state_q == StIdle)),
    .valid0_i    (bus.req0_valid),
    .valid1_i    (bus.req1_valid),
    .last_grant_i(last_grant_q),
    .grant0_o    (grant0),
    .grant1_o    (grant1)
  );

  assign accept        = grant0 | grant1;
  assign accept_data   = grant1 ? bus.req1_data : bus.req0_data;
  assign shreg_nxt     = shreg_q << 1;
  assign div_wrap      = (div_q == DivLast);
  // A live request on the trigger cycle pre-empts the refresh.
  assign refresh_start = (REFRESH_CYC != 0) && (state_q == StIdle) && !accept &&
                         (idle_q == IdleTrig);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      div_q         <= '0;
      bit_q         <= '0;
      idle_q        <= '0;
      shreg_q       <= '0;
      shadow_q      <= '0;
      last_grant_q  <= 1'b1;
      data_q        <= 1'b0;
      data_clk_q    <= 1'b0;
      refresh_clk_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          div_q <= '0;
          if (accept) begin
            shreg_q      <= accept_data;
            shadow_q     <= accept_data;
            last_grant_q <= grant1;
            idle_q       <= '0;
            bit_q        <= BitLast;
            data_q       <= accept_data[DATA_W-1];
            state_q      <= StShift;
          end else if (refresh_start) begin
            shreg_q <= shadow_q;
            idle_q  <= '0;
            bit_q   <= BitLast;
            data_q  <= shadow_q[DATA_W-1];
            state_q <= StShift;
          end else if (idle_q != '1) begin
            idle_q <= idle_q + 1'b1;
          end
        end
        StShift: begin
          div_q <= div_wrap ? '0 : div_q + 1'b1;
          if (div_wrap) begin
            if (!data_clk_q) begin
              data_clk_q <= 1'b1;
            end else begin
              data_clk_q <= 1'b0;
              if (bit_q == '0) begin
                data_q        <= 1'b0;
                refresh_clk_q <= 1'b1;
                state_q       <= StLatch;
              end else begin
                bit_q   <= bit_q - 1'b1;
                shreg_q <= shreg_nxt;
                data_q  <= shreg_nxt[DATA_W-1];
              end
            end
          end
        end
        StLatch: begin
          div_q <= div_wrap ? '0 : div_q + 1'b1;
          if (div_wrap) begin
            refresh_clk_q <= 1'b0;
            state_q       <= StGap;
            frame_done_q  <= (CLK_DIV == 1);
          end
        end
        StGap: begin
          div_q <= div_wrap ? '0 : div_q + 1'b1;
          // frame_done is registered, so raise it one cycle ahead of the last GAP cycle.
          if (div_wrap) state_q <= StIdle;
          else          frame_done_q <= (div_q == DivPre);
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req0_ready            = grant0;
  assign bus.req1_ready            = grant1;
  assign bus.busy                  = (state_q != StIdle);
  assign bus.frame_done            = frame_done_q;
  assign bus.last_grant            = last_grant_q;
  assign bus.SN74HC595_data        = data_q;
  assign bus.SN74HC595_data_clk    = data_clk_q;
  assign bus.SN74HC595_refresh_clk = refresh_clk_q;

endmodule
